// File: rtl/pid_pkg.sv
// Shared definitions for the PID duty controller: widths, FSM encoding and
// the duty saturation helpers.
package pid_pkg;

  localparam int ADC_W    = 12;
  localparam int DUTY_W   = 15;
  localparam int DUTY_MAX = 32767;
  localparam int COEF_W   = 16;
  localparam int FRAC     = 8;
  localparam int ACC_W    = 32;
  localparam int INT_LIM  = (32'sd1 <<< (DUTY_W + FRAC)) - 32'sd1;

  localparam int E_W    = ADC_W + 1;
  localparam int DE_W   = ADC_W + 2;
  localparam int PROD_W = DE_W + COEF_W + 1;
  localparam int SUM_W  = ACC_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ERR  = 3'd1,
    ST_PROP = 3'd2,
    ST_INTG = 3'd3,
    ST_DERV = 3'd4,
    ST_SUM  = 3'd5
  } pid_state_t;

  typedef enum logic [1:0] {
    MAC_KP = 2'd0,
    MAC_KI = 2'd1,
    MAC_KD = 2'd2
  } mac_sel_t;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic signed [SUM_W-1:0] u);
    logic [DUTY_W-1:0] r;
    if (u[SUM_W-1]) begin
      r = {DUTY_W{1'b0}};
    end else if (u > SUM_W'(DUTY_MAX)) begin
      r = DUTY_W'(DUTY_MAX);
    end else begin
      r = u[DUTY_W-1:0];
    end
    return r;
  endfunction

  function automatic logic is_clamped(input logic signed [SUM_W-1:0] u);
    return u[SUM_W-1] | (u > SUM_W'(DUTY_MAX));
  endfunction

endpackage

// File: rtl/pid_duty_ctrl_if.sv
// Sample-in / duty-out bundle between the ADC front end, the PID core and the
// PWM stage.
interface pid_duty_ctrl_if;
  import pid_pkg::*;

  logic [ADC_W-1:0]  adc_data;
  logic              adc_valid;
  logic [ADC_W-1:0]  setpoint;
  logic [COEF_W-1:0] kp;
  logic [COEF_W-1:0] ki;
  logic [COEF_W-1:0] kd;
  logic [DUTY_W-1:0] duty;
  logic              duty_valid;
  logic              busy;
  logic              sat;
  logic              overrun;

  modport master (
    output adc_data, adc_valid, setpoint, kp, ki, kd,
    input  duty, duty_valid, busy, sat, overrun
  );

  modport slave (
    input  adc_data, adc_valid, setpoint, kp, ki, kd,
    output duty, duty_valid, busy, sat, overrun
  );

endinterface

// File: rtl/pid_mac.sv
// Single shared signed multiplier; the selector picks which error term and
// which gain feed it in the current FSM state.
module pid_mac
  import pid_pkg::*;
(
  input  mac_sel_t                  sel,
  input  logic signed [E_W-1:0]     e,
  input  logic signed [DE_W-1:0]    de,
  input  logic [COEF_W-1:0]         kp,
  input  logic [COEF_W-1:0]         ki,
  input  logic [COEF_W-1:0]         kd,
  output logic signed [PROD_W-1:0]  prod
);

  logic signed [DE_W-1:0]   op_a_s;
  logic signed [COEF_W:0]   op_b_s;

  // Operand select: gains are zero-extended so they stay non-negative.
  always_comb begin
    op_a_s = {e[E_W-1], e};
    op_b_s = {1'b0, kp};
    case (sel)
      MAC_KP: begin
        op_a_s = {e[E_W-1], e};
        op_b_s = {1'b0, kp};
      end
      MAC_KI: begin
        op_a_s = {e[E_W-1], e};
        op_b_s = {1'b0, ki};
      end
      MAC_KD: begin
        op_a_s = de;
        op_b_s = {1'b0, kd};
      end
      default: begin
        op_a_s = {e[E_W-1], e};
        op_b_s = {1'b0, kp};
      end
    endcase
  end

  // Full-width product; both operands signed so no bits are lost.
  always_comb begin
    prod = op_a_s * op_b_s;
  end

endmodule

// File: rtl/pid_duty_ctrl.sv
// Multi-cycle PID controller: one ADC sample in, one saturated duty word out
// five cycles later, sharing a single multiplier across P, I and D terms.
module pid_duty_ctrl
  import pid_pkg::*;
(
  input  logic            clk_dev,
  input  logic            reset,
  input  logic            enable,
  pid_duty_ctrl_if.slave  bus
);

  localparam logic signed [ACC_W:0]   LIM_HI = (ACC_W + 1)'(INT_LIM);
  localparam logic signed [ACC_W:0]   LIM_LO = -LIM_HI;
  localparam logic signed [ACC_W-1:0] ACC_HI = ACC_W'(INT_LIM);
  localparam logic signed [ACC_W-1:0] ACC_LO = -ACC_HI;

  pid_state_t state_r, state_nxt_s;

  logic [ADC_W-1:0]          adc_r, sp_r;
  logic [COEF_W-1:0]         kp_r, ki_r, kd_r;
  logic signed [E_W-1:0]     e_r, e_prev_r, e_s;
  logic signed [DE_W-1:0]    de_r, de_s;
  logic signed [PROD_W-1:0]  p_r, d_r, prod_s;
  logic signed [ACC_W-1:0]   acc_r, acc_nxt_s;
  logic signed [ACC_W:0]     cand_s;
  logic signed [SUM_W-1:0]   sum_s, u_s;
  logic                      wind_hold_s;
  mac_sel_t                  sel_s;

  logic [DUTY_W-1:0] duty_r;
  logic              duty_valid_r, busy_r, sat_r, overrun_r;

  // State register; disable parks the FSM in IDLE like reset does.
  always_ff @(posedge clk_dev) begin
    if (!reset || !enable) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: a fixed one-cycle-per-step walk once a sample is accepted.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.adc_valid) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ERR:  state_nxt_s = ST_PROP;
      ST_PROP: state_nxt_s = ST_INTG;
      ST_INTG: state_nxt_s = ST_DERV;
      ST_DERV: state_nxt_s = ST_SUM;
      ST_SUM:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Multiplier operand selection per state.
  always_comb begin
    sel_s = MAC_KP;
    case (state_r)
      ST_INTG: sel_s = MAC_KI;
      ST_DERV: sel_s = MAC_KD;
      default: sel_s = MAC_KP;
    endcase
  end

  pid_mac u_mac (
    .sel  (sel_s),
    .e    (e_r),
    .de   (de_r),
    .kp   (kp_r),
    .ki   (ki_r),
    .kd   (kd_r),
    .prod (prod_s)
  );

  // Error terms from the latched sample.
  always_comb begin
    e_s  = $signed({1'b0, sp_r}) - $signed({1'b0, adc_r});
    de_s = {e_s[E_W-1], e_s} - {e_prev_r[E_W-1], e_prev_r};
  end

  // Integrator candidate with clamp; hold it while pushing further into a rail.
  always_comb begin
    cand_s = {acc_r[ACC_W-1], acc_r}
           + {{(ACC_W + 1 - PROD_W){prod_s[PROD_W-1]}}, prod_s};
    if (cand_s > LIM_HI) begin
      acc_nxt_s = ACC_HI;
    end else if (cand_s < LIM_LO) begin
      acc_nxt_s = ACC_LO;
    end else begin
      acc_nxt_s = cand_s[ACC_W-1:0];
    end
    wind_hold_s = sat_r &&
                  (((duty_r == DUTY_W'(DUTY_MAX)) && !e_r[E_W-1] && (e_r != {E_W{1'b0}})) ||
                   ((duty_r == {DUTY_W{1'b0}}) && e_r[E_W-1]));
  end

  // Final sum is wide enough that p + acc + d can never wrap.
  always_comb begin
    sum_s = {{(SUM_W - PROD_W){p_r[PROD_W-1]}}, p_r}
          + {{(SUM_W - ACC_W){acc_r[ACC_W-1]}}, acc_r}
          + {{(SUM_W - PROD_W){d_r[PROD_W-1]}}, d_r};
    u_s   = sum_s >>> FRAC;
  end

  // Datapath and output registers; disable clears the same state as reset.
  always_ff @(posedge clk_dev) begin
    if (!reset || !enable) begin
      adc_r        <= {ADC_W{1'b0}};
      sp_r         <= {ADC_W{1'b0}};
      kp_r         <= {COEF_W{1'b0}};
      ki_r         <= {COEF_W{1'b0}};
      kd_r         <= {COEF_W{1'b0}};
      e_r          <= {E_W{1'b0}};
      e_prev_r     <= {E_W{1'b0}};
      de_r         <= {DE_W{1'b0}};
      p_r          <= {PROD_W{1'b0}};
      d_r          <= {PROD_W{1'b0}};
      acc_r        <= {ACC_W{1'b0}};
      duty_r       <= {DUTY_W{1'b0}};
      duty_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      sat_r        <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      duty_valid_r <= 1'b0;
      overrun_r    <= bus.adc_valid && (state_r != ST_IDLE);
      busy_r       <= (state_nxt_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (bus.adc_valid) begin
            adc_r <= bus.adc_data;
            sp_r  <= bus.setpoint;
            kp_r  <= bus.kp;
            ki_r  <= bus.ki;
            kd_r  <= bus.kd;
          end
        end
        ST_ERR: begin
          e_r  <= e_s;
          de_r <= de_s;
        end
        ST_PROP: p_r <= prod_s;
        ST_INTG: begin
          if (!wind_hold_s) begin
            acc_r <= acc_nxt_s;
          end
        end
        ST_DERV: d_r <= prod_s;
        ST_SUM: begin
          duty_r       <= clamp_duty(u_s);
          sat_r        <= is_clamped(u_s);
          e_prev_r     <= e_r;
          duty_valid_r <= 1'b1;
        end
        default: duty_valid_r <= 1'b0;
      endcase
    end
  end

  assign bus.duty       = duty_r;
  assign bus.duty_valid = duty_valid_r;
  assign bus.busy       = busy_r;
  assign bus.sat        = sat_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_pid_duty_ctrl.sv
// Scoreboard bench for pid_duty_ctrl: directed control-law cases plus random
// samples, each predicted by a plain-arithmetic PID model.
module tb_pid_duty_ctrl;
  import pid_pkg::*;

  logic clk_dev = 1'b0;
  logic reset   = 1'b0;
  logic enable  = 1'b0;

  pid_duty_ctrl_if bus();

  pid_duty_ctrl dut (
    .clk_dev (clk_dev),
    .reset   (reset),
    .enable  (enable),
    .bus     (bus)
  );

  always #5 clk_dev = ~clk_dev;

  longint cyc = 0;
  always @(posedge clk_dev) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int ovr_seen = 0;

  typedef struct {
    int     duty;
    bit     sat;
    longint due;
  } exp_t;
  exp_t sb_q[$];

  // reference model state
  longint acc_m;
  int     eprev_m;
  int     last_duty_m;
  bit     last_sat_m;

  function automatic void model_clear();
    acc_m = 0; eprev_m = 0; last_duty_m = 0; last_sat_m = 0;
  endfunction

  function automatic void model_step(input int adc, input int sp, input int kp_v,
                                     input int ki_v, input int kd_v,
                                     output int duty_o, output bit sat_o);
    int e, de;
    bit hold;
    longint u, lim;
    lim  = (longint'(1) << 23) - 1;
    e    = sp - adc;
    de   = e - eprev_m;
    hold = last_sat_m && ((last_duty_m == 32767 && e > 0) || (last_duty_m == 0 && e < 0));
    if (!hold) begin
      acc_m = acc_m + longint'(ki_v) * e;
      if (acc_m > lim) acc_m = lim;
      if (acc_m < -lim) acc_m = -lim;
    end
    u = (longint'(kp_v) * e + acc_m + longint'(kd_v) * de) >>> 8;
    if (u < 0) duty_o = 0;
    else if (u > 32767) duty_o = 32767;
    else duty_o = int'(u);
    sat_o       = (u < 0) || (u > 32767);
    eprev_m     = e;
    last_duty_m = duty_o;
    last_sat_m  = sat_o;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every duty_valid pulse must match the oldest prediction.
  always @(negedge clk_dev) begin : monitor
    exp_t x;
    if (bus.duty_valid) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_duty_valid: got duty %0d, expected no pulse (cycle %0d)",
                 bus.duty, cyc);
      end else begin
        x = sb_q.pop_front();
        check("duty", longint'(bus.duty), longint'(x.duty));
        check("sat", longint'(bus.sat), longint'(x.sat));
        check("latency", cyc, x.due);
      end
    end
    if (bus.overrun) ovr_seen++;
  end

  // Caller sits just after a negedge; gap extra negedges follow the strobe.
  task automatic issue(input int adc, input int sp, input int kp_v, input int ki_v,
                       input int kd_v, input int gap);
    int d;
    bit s;
    exp_t x;
    bus.adc_data  = 12'(adc);
    bus.setpoint  = 12'(sp);
    bus.kp        = 16'(kp_v);
    bus.ki        = 16'(ki_v);
    bus.kd        = 16'(kd_v);
    bus.adc_valid = 1'b1;
    model_step(adc, sp, kp_v, ki_v, kd_v, d, s);
    x.duty = d; x.sat = s; x.due = cyc + 6;
    sb_q.push_back(x);
    @(negedge clk_dev);
    bus.adc_valid = 1'b0;
    repeat (gap) @(negedge clk_dev);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() > 0; i++) @(negedge clk_dev);
    check("drain", longint'(sb_q.size()), 0);
  endtask

  task automatic disable_pulse();
    enable = 1'b0;
    bus.adc_valid = 1'b1;
    @(negedge clk_dev);
    bus.adc_valid = 1'b0;
    check("dis_duty", longint'(bus.duty), 0);
    check("dis_sat", longint'(bus.sat), 0);
    check("dis_busy", longint'(bus.busy), 0);
    check("dis_overrun", longint'(bus.overrun), 0);
    enable = 1'b1;
    model_clear();
    @(negedge clk_dev);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin : stim
    int adc, sp, kp_v, ki_v, kd_v;
    bus.adc_data = '0; bus.setpoint = '0; bus.adc_valid = 1'b0;
    bus.kp = '0; bus.ki = '0; bus.kd = '0;
    model_clear();
    repeat (3) @(negedge clk_dev);
    check("rst_duty", longint'(bus.duty), 0);
    check("rst_duty_valid", longint'(bus.duty_valid), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_sat", longint'(bus.sat), 0);
    check("rst_overrun", longint'(bus.overrun), 0);
    reset = 1'b1; enable = 1'b1;
    @(negedge clk_dev);

    // P-only: 1000-200 at gain 1.0 -> 800
    issue(200, 1000, 256, 0, 0, 0);
    check("busy_rise", longint'(bus.busy), 1);
    repeat (5) @(negedge clk_dev);
    check("busy_fall", longint'(bus.busy), 0);
    check("p_only_duty", longint'(bus.duty), 800);

    // Saturation high then low
    issue(200, 1000, 16384, 0, 0, 5);
    issue(1200, 1000, 16384, 0, 0, 5);
    drain();

    // Integrator: 50, 100, 150 at back-to-back maximum rate
    issue(900, 1000, 0, 128, 0, 5);
    issue(900, 1000, 0, 128, 0, 5);
    issue(900, 1000, 0, 128, 0, 5);
    drain();
    check("intg_duty", longint'(bus.duty), 150);

    // Disable clears integrator: next sample restarts at 50
    disable_pulse();
    issue(900, 1000, 0, 128, 0, 5);
    drain();
    check("intg_cleared", longint'(bus.duty), 50);

    // Derivative: e = 0, 100, 100 -> 0, 100, 0
    disable_pulse();
    issue(500, 500, 0, 0, 256, 5);
    issue(400, 500, 0, 0, 256, 5);
    issue(400, 500, 0, 0, 256, 5);
    drain();

    // Anti-windup: drive into the top rail, then reverse the error
    for (int i = 0; i < 10; i++) issue(1000, 1100, 256, 16384, 0, 5);
    issue(1000, 900, 256, 16384, 0, 5);
    drain();
    check("aw_drop", longint'(bus.duty < 15'd32767), 1);
    disable_pulse();

    // Overrun during INTG: sample dropped, single duty_valid
    issue(600, 1000, 256, 0, 0, 2);
    bus.adc_data = 12'd0; bus.adc_valid = 1'b1;
    @(negedge clk_dev);
    bus.adc_valid = 1'b0;
    check("overrun_intg", longint'(bus.overrun), 1);
    repeat (3) @(negedge clk_dev);

    // Overrun in the SUM cycle: also dropped
    issue(700, 1000, 256, 0, 0, 4);
    bus.adc_data = 12'd0; bus.adc_valid = 1'b1;
    @(negedge clk_dev);
    bus.adc_valid = 1'b0;
    check("overrun_sum", longint'(bus.overrun), 1);
    drain();
    check("overrun_count", longint'(ovr_seen), 2);

    // Reset during DERV: no result, busy and duty cleared at once
    issue(300, 1000, 256, 0, 0, 3);
    reset = 1'b0;
    void'(sb_q.pop_back());
    model_clear();
    @(negedge clk_dev);
    check("rst_mid_busy", longint'(bus.busy), 0);
    check("rst_mid_duty", longint'(bus.duty), 0);
    check("rst_mid_valid", longint'(bus.duty_valid), 0);
    reset = 1'b1;
    repeat (8) @(negedge clk_dev);

    // Random samples against the model
    for (int n = 0; n < 40; n++) begin
      adc  = int'($urandom_range(0, 4095));
      sp   = int'($urandom_range(0, 4095));
      kp_v = int'($urandom_range(0, 1023));
      ki_v = int'($urandom_range(0, 255));
      kd_v = int'($urandom_range(0, 511));
      if ($urandom_range(0, 7) == 0) kp_v = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0) ki_v = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0) kd_v = int'($urandom_range(0, 65535));
      issue(adc, sp, kp_v, ki_v, kd_v, int'($urandom_range(5, 8)));
    end
    drain();
    check("overrun_final", longint'(ovr_seen), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pid_duty_ctrl.md
Name: pid_duty_ctrl

Overview:
Discrete PID controller that converts ADC samples into the 15-bit duty word consumed by the downstream PWM/dead-time stage.
- Each sample is accepted with a valid strobe.
- The control law is computed over a short multi-cycle sequence using one shared multiplier.
- The result is saturated to the PWM range, and the held `duty` output is updated with a one-cycle `duty_valid` pulse.

Parameters:
- ADC_W, 12, ADC sample and setpoint width (unsigned).
- DUTY_W, 15, duty output width; must match the PWM data width.
- DUTY_MAX, 32767, upper clamp for duty (minimum is 0).
- COEF_W, 16, gain width; unsigned fixed-point Q(COEF_W-FRAC).FRAC.
- FRAC, 8, fractional bits of the gains; sum is arithmetically shifted right by FRAC.
- ACC_W, 32, integrator accumulator width (signed).
- INT_LIM, 2^(DUTY_W+FRAC)-1, symmetric clamp magnitude of the integrator accumulator.

Ports:
- clk_dev, in, 1, divided clock shared with the PWM counter domain.
- reset, in, 1, synchronous, active-low.
- enable, in, 1, controller enable; low forces output 0 and clears state.
- adc_data, in, ADC_W, measured value.
- adc_valid, in, 1, one-cycle strobe qualifying adc_data.
- setpoint, in, ADC_W, target value; sampled together with adc_data.
- kp, in, COEF_W, proportional gain.
- ki, in, COEF_W, integral gain.
- kd, in, COEF_W, derivative gain; all gains are sampled together with adc_data.
- duty, out, DUTY_W, registered duty word to the PWM stage.
- duty_valid, out, 1, one-cycle pulse when duty is updated.
- busy, out, 1, high while a computation is in progress.
- sat, out, 1, registered; high if the last result was clamped (low or high).
- overrun, out, 1, one-cycle pulse when adc_valid arrives while busy.

Behaviour:
- Reset (reset=0 at a clk_dev edge):
  - duty=0, duty_valid=0, busy=0, sat=0, overrun=0.
  - Integrator=0, e_prev=0, FSM=IDLE.
  - Takes effect even mid-computation; no duty_valid is produced for the aborted sample.
- enable=0: same clearing as reset, except the FSM simply stays in IDLE. adc_valid is ignored and overrun does not pulse.
- FSM states: IDLE -> ERR -> PROP -> INTG -> DERV -> SUM -> IDLE. Exactly one state per clk_dev cycle.
- IDLE:
  - On adc_valid with enable=1, latch adc_data, setpoint and gains, then go to ERR.
  - busy rises the following cycle.
- ERR: e = setpoint - adc_data, signed, ADC_W+1 bits. de = e - e_prev, signed, ADC_W+2 bits.
- PROP: p = kp * e. Gains are zero-extended to signed.
- INTG: i_inc = ki * e.
  - Candidate acc' = acc + i_inc, clamped to [-INT_LIM, +INT_LIM].
  - Anti-windup: acc is not updated if the previous result had sat=1 at DUTY_MAX and e>0, or sat=1 at 0 and e<0.
- DERV: d = kd * de.
- SUM:
  - u = (p + acc + d) >>> FRAC, with an arithmetic shift and at least ACC_W+2 bits internally; no overflow is allowed.
  - duty = clamp(u, 0, DUTY_MAX); sat = (u<0 or u>DUTY_MAX).
  - e_prev <= e; duty_valid=1 for this one cycle; busy drops the next cycle.
- Latency: adc_valid at edge N -> duty and duty_valid at edge N+5. Maximum sample rate is one per 6 cycles.
- adc_valid while busy: the sample is dropped, overrun pulses for one cycle, and the current computation is unaffected.
- adc_valid in the same cycle as SUM -> IDLE: treated as busy and dropped.
- duty holds its value between updates; it never glitches outside SUM.
- The multiplier is a single shared signed (ADC_W+2) x (COEF_W+1) unit, combinational within its state. No multi-cycle path.

Decomposition:
- Shared package pid_pkg: FSM state encoding, FRAC, and the saturation helper function clamp_duty.
- One sub-module, pid_mac: the shared signed multiplier plus an operand-select mux, with the width rules above.

Test Plan:
- P-only: kp=256 (1.0), ki=kd=0, setpoint=1000, adc=200 -> duty=800, sat=0, duty_valid exactly 5 cycles after adc_valid.
- Saturation: kp=16384 (64.0), e=800 -> duty=32767, sat=1. Then adc=1200 (e=-200) -> duty=0, sat=1.
- Integrator: kp=0, ki=128 (0.5), e=100, three samples -> duty 50, 100, 150.
- Anti-windup: ki=16384, drive to DUTY_MAX for 10 samples, then e=-100 -> duty drops below 32767 on the first negative sample. Accumulator checked equal to its value at first saturation.
- Derivative: kd=256, kp=ki=0, e sequence 0, 100, 100 -> duty 0, 100, 0.
- Robustness:
  - adc_valid during INTG -> overrun pulse, single duty_valid.
  - reset low during DERV -> next cycle busy=0, duty=0, no duty_valid.
  - enable low -> duty=0 and integrator cleared.
